uart_tx_queue: RTL

//  Byte queue feeding the uart transmitter's transmit/tx_byte inputs.
//  - Host logic (command/response engine) writes bytes at clock rate.
//  - Block buffers them in a FIFO and launches each with a one-cycle transmit pulse.
//  - Uses is_transmitting to pace launches, one byte per frame.

---
 rtl/uart_tx_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO in front of a uart transmitter. It launches one queued byte per frame,
// paced by uart_is_transmitting, and flags launches that the uart never acknowledges.
module uart_tx_queue #(
  parameter int unsigned DEPTH_BITS    = 4,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_stb,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  output logic                  tx_err,
  output logic                  busy,
  output logic                  uart_transmit,
  output logic [7:0]            uart_tx_byte,
  input  logic                  uart_is_transmitting
);

  localparam int unsigned Depth = 1 << DEPTH_BITS;
  localparam int unsigned CntW  = DEPTH_BITS + 1;
  localparam int unsigned TmoW  = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWaitStart, StWaitDone} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_err_q, tx_err_d;
  logic                  uart_transmit_q, uart_transmit_d;
  logic [7:0]            uart_tx_byte_q, uart_tx_byte_d;
  logic [7:0]            mem_q [Depth];

  logic full_w, empty_w, push, launch;

  assign full_w  = (count_q == CntW'(Depth));
  assign empty_w = (count_q == '0);
  // full is taken from the registered count, so a same-cycle pop never frees room for a write
  assign push    = wr_stb && !flush && !full_w;
  assign launch  = (state_q == StIdle) && !empty_w && !uart_is_transmitting && !flush;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    tmo_d           = tmo_q;
    overflow_d      = overflow_q;
    tx_err_d        = tx_err_q;
    uart_transmit_d = 1'b0;
    uart_tx_byte_d  = uart_tx_byte_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (launch) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(launch);
      if (wr_stb && full_w) overflow_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          uart_tx_byte_d  = mem_q[rd_ptr_q];
          uart_transmit_d = 1'b1;
          tmo_d           = '0;
          state_d         = StWaitStart;
        end
      end
      StWaitStart: begin
        if (uart_is_transmitting) begin
          state_d = StWaitDone;
        end else if (tmo_q == TmoW'(START_TIMEOUT - 1)) begin
          // Unacknowledged launch: the popped byte is dropped
          tx_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!uart_is_transmitting) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      tmo_q           <= '0;
      overflow_q      <= 1'b0;
      tx_err_q        <= 1'b0;
      uart_transmit_q <= 1'b0;
      uart_tx_byte_q  <= 8'h00;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      tmo_q           <= tmo_d;
      overflow_q      <= overflow_d;
      tx_err_q        <= tx_err_d;
      uart_transmit_q <= uart_transmit_d;
      uart_tx_byte_q  <= uart_tx_byte_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full          = full_w;
  assign empty         = empty_w;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign tx_err        = tx_err_q;
  assign busy          = (state_q != StIdle) || !empty_w;
  assign uart_transmit = uart_transmit_q;
  assign uart_tx_byte  = uart_tx_byte_q;

endmodule
